// File: rtl/if_stage_buf.sv
// if_stage_buf: buffered pre-IF/IF fetch stage over a split req/addr_ok/data_ok inst SRAM.
// Keeps up to BUF_DEPTH fetches in flight or buffered; a taken branch cancels them and redirects.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  instruction FIFO depth and cap on in-flight + buffered fetches (power of 2, >= 2)
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   ds_allowin                 ID accepts an instruction this cycle
//   br_bus[32:0]               {br_taken, br_target}; br_taken is a one-cycle pulse
//   fs_to_ds_valid             instruction FIFO head is valid
//   fs_to_ds_bus               FIFO head: {inst, pc}, or {adef, inst, pc} with IF_ADEF_EN
//   inst_sram_*                split request/response instruction SRAM interface
//
// Optional build macro IF_ADEF_EN: misaligned fetch_pc issues no request; once the pipe has
// drained it pushes a single {1, 0, fetch_pc} entry and fetch halts until the next branch.

module if_stage_buf #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
`ifdef IF_ADEF_EN
    output logic [64:0] fs_to_ds_bus,
`else
    output logic [63:0] fs_to_ds_bus,
`endif
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

`ifdef IF_ADEF_EN
    localparam int BW = 65;
`else
    localparam int BW = 64;
`endif
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(BUF_DEPTH);

    logic          br_taken;
    logic [31:0]   br_target;

    logic [31:0]   fetch_pc;

    logic [31:0]   tag_q [BUF_DEPTH];
    logic [PW-1:0] tag_rd;
    logic [PW-1:0] tag_wr;

    logic [BW-1:0] ibuf [BUF_DEPTH];
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;

    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;

    logic [CW+1:0] used;
    logic          credit;
    logic          req_ok;
    logic          accept;
    logic          resp_keep;
    logic          resp_drop;
    logic          adef_push;
    logic          buf_push;
    logic          buf_pop;
    logic [BW-1:0] push_ent;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Every issued, buffered or still-owed fetch consumes one slot.
    assign used = (CW + 2)'(inflight) + (CW + 2)'(drop_cnt) + (CW + 2)'(buf_cnt);
    assign credit = used < DEPTH_W;

`ifdef IF_ADEF_EN
    logic halted;
    logic misalign;

    assign misalign = |fetch_pc[1:0];
    assign req_ok   = !misalign && !halted;

    // Report the fault only once nothing older can still reach ID.
    assign adef_push = misalign && !halted && !br_taken && !reset
                    && (inflight == '0) && (drop_cnt == '0)
                    && (buf_cnt < DEPTH_C);

    assign push_ent = resp_keep ? {1'b0, inst_sram_rdata, tag_q[tag_rd]}
                                : {1'b1, 32'h0, fetch_pc};
    assign inst_sram_addr = fetch_pc;
`else
    assign req_ok    = 1'b1;
    assign adef_push = 1'b0;
    assign push_ent  = {inst_sram_rdata, tag_q[tag_rd]};
    assign inst_sram_addr = {fetch_pc[31:2], 2'b00};
`endif

    assign inst_sram_req   = !reset && !br_taken && credit && req_ok;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign accept    = inst_sram_req && inst_sram_addr_ok;
    assign resp_keep = inst_sram_data_ok && (drop_cnt == '0);
    assign resp_drop = inst_sram_data_ok && (drop_cnt != '0);
    assign buf_push  = resp_keep || adef_push;

    assign fs_to_ds_valid = (buf_cnt != '0) && !br_taken;
    assign fs_to_ds_bus   = ibuf[buf_rd];
    assign buf_pop        = fs_to_ds_valid && ds_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            tag_rd   <= '0;
            tag_wr   <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            buf_cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                tag_q[i] <= '0;
                ibuf[i]  <= '0;
            end
        end else if (br_taken) begin
            // Everything kept becomes owed; a response landing now
            // settles one of those debts immediately.
            fetch_pc <= br_target;
            tag_rd   <= '0;
            tag_wr   <= '0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            buf_cnt  <= '0;
            inflight <= '0;
            drop_cnt <= drop_cnt + inflight - CW'(inst_sram_data_ok);
        end else begin
            if (accept) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + 1'b1;
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (resp_keep) begin
                tag_rd <= tag_rd + 1'b1;
            end
            inflight <= inflight + CW'(accept) - CW'(resp_keep);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (buf_push) begin
                ibuf[buf_wr] <= push_ent;
                buf_wr       <= buf_wr + 1'b1;
            end
            if (buf_pop) begin
                buf_rd <= buf_rd + 1'b1;
            end
            buf_cnt <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
        end
    end

`ifdef IF_ADEF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (br_taken) begin
            halted <= 1'b0;
        end else if (adef_push) begin
            halted <= 1'b1;
        end
    end
`endif

endmodule
